spi_eeprom_responder: RTL and testbench
=======================================

# spi_eeprom_responder

SPI slave that emulates a 25xx-series serial EEPROM: it decodes READ/WRITE/WREN/WRDI/RDSR/WRSR, holds a byte-wide memory array and drives MISO back to the SPI master of the AXI-Lite-to-SPI bridge. It runs entirely in the bus2ip_clk domain, oversampling the SPI pins, and is the on-chip target for bridge bring-up and loopback regression.

## Interface
- MEM_DEPTH, 256: memory size in bytes, power of two, 16..4096; address wraps modulo MEM_DEPTH.
- PAGE_SIZE, 16: write-page size in bytes, power of two, ≤ MEM_DEPTH.
- bus2ip_clk  in  1  block clock (16 MHz nominal).
- rst  in  1  reset, synchronous, active-high; clock bus2ip_clk.
- cpol  in  1  SCK idle level; static while SPI_CS is low.
- cpha  in  1  0: sample on leading edge, 1: sample on trailing edge.
- SPI_SCK  in  1  serial clock from master, asynchronous.
- SPI_CS  in  1  chip select, active-low, asynchronous.
- SPI_MOSI  in  1  master-to-slave data, MSB first.
- SPI_MISO  out  1  slave-to-master data, MSB first; 1 when not driving data.
- wel  out  1  write-enable latch.
- bp  out  2  block-protect bits (status[3:2]).
- rx_valid  out  1  one-cycle pulse per completed received byte.
- rx_byte  out  8  last completed received byte, valid with rx_valid.

## Operation
- SCK, CS, MOSI pass through 2-FF synchronizers; a third register gives edge detect. Leading edge = SCK leaving cpol level; trailing = returning. Sample edge = leading if cpha=0, else trailing; other edge = shift edge.
- CS falling (sync): bit counter = 0, state = CMD; with cpha=0 MISO is loaded immediately (1 in CMD).
- Each sample edge shifts MOSI into rx shifter; 8th sample: rx_valid pulse, rx_byte updated, counter wraps to 0, state advances.
- States: IDLE, CMD, ADDR_HI, ADDR_LO, READ, WRITE, RDSR, WRSR, IGNORE.
- CMD byte: 0x03→ADDR_HI(read); 0x02→ADDR_HI(write); 0x05→RDSR; 0x01→WRSR; 0x06/0x04→IGNORE with pending set/clear of WEL; any other→IGNORE.
- ADDR_HI→ADDR_LO→READ or WRITE; address = 16 received bits, low log2(MEM_DEPTH) used.
- READ: tx shifter loaded with mem[addr] one cycle after 8th sample of previous byte; addr increments per byte, wraps at MEM_DEPTH.
- WRITE: each complete byte stored to mem[addr] only if wel=1; addr increments within page (low log2(PAGE_SIZE) bits wrap, upper bits fixed).
- RDSR: status = {4'b0, bp, wel, 1'b0 (WIP, always 0)}, repeated every byte until CS rise.
- WRSR: first complete byte sets bp = byte[3:2] if wel=1; further bytes ignored.
- CS rising: state = IDLE, MISO = 1, partial byte discarded. WREN/WRDI take effect only if exactly 8 bits were clocked. wel cleared at CS rise ending WRITE or WRSR that stored ≥1 byte.
- IGNORE: MISO = 1, no memory or status effect.
- Memory not affected by rst; power-up contents 0xFF.

## Timing
- Reset values: SPI_MISO=1, wel=0, bp=00, rx_valid=0, rx_byte=0x00, state IDLE.
- rst while CS low: state IDLE; block ignores SCK until a full CS rise then fall is seen.
- Pin-to-action latency: 3 bus2ip_clk from SCK/CS pin edge to internal action; MISO changes 4 cycles after pin shift edge.
- Supported SCK: each half-period ≥ 4 bus2ip_clk (bridge DIV 10 or 11); CS setup/hold to first/last SCK edge ≥ 4 cycles.
- rx_valid asserts 3 cycles after 8th sampling pin edge, exactly 1 cycle wide.
- Memory write occurs in the rx_valid cycle; read-after-write of same address in a later transaction returns new data.
- CS rise and SCK edge in same synchronized cycle: CS rise wins, edge ignored.

## Test plan
- Mode 0, WREN; WRITE 0x0010 data 0xA5,0x5A; READ 0x0010 two bytes → MISO 0xA5,0x5A; wel=0 after write CS rise.
- WRITE without WREN to 0x0020 data 0x11; READ 0x0020 → 0xFF.
- WREN; RDSR → 0x02; WRDI; RDSR → 0x00; WREN; WRSR 0x0C; RDSR → 0x0C, bp=11, wel=0.
- WREN; WRITE 0x001E data 0x01..0x04 → bytes at 0x1E,0x1F,0x10,0x11 (page wrap); READ 0x00FF three bytes → mem[0xFF],mem[0x00],mem[0x01].
- Repeat first scenario in modes 1, 2, 3 (cpol/cpha) → identical data.
- Assert rst mid-READ, then 4 SCK pulses with CS low → MISO=1, no rx_valid; next CS cycle READ works; WREN with 7 bits then CS rise → wel stays 0.

Source files
------------

// File: rtl/spi_eeprom_responder.sv
// SPI slave emulating a 25xx-series serial EEPROM (READ/WRITE/WREN/WRDI/RDSR/WRSR).
// All SPI pins are oversampled in the bus2ip_clk domain.
module spi_eeprom_responder #(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned PAGE_SIZE = 16
) (
   input  logic       bus2ip_clk,
   input  logic       rst,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       SPI_SCK,
   input  logic       SPI_CS,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO,
   output logic       wel,
   output logic [1:0] bp,
   output logic       rx_valid,
   output logic [7:0] rx_byte
);
   localparam int unsigned AW = $clog2(MEM_DEPTH);
   localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);

   typedef enum logic [3:0] {
      IDLE, CMD, ADDR_HI, ADDR_LO, READ, WRITE, RDSR, WRSR, IGNORE
   } state_t;

   typedef enum logic [1:0] {WOP_NONE, WOP_SET, WOP_CLR} wop_t;

   state_t        state, state_nxt;
   logic [2:0]    sck_sync, cs_sync;
   logic [1:0]    mosi_sync;
   logic [2:0]    bit_cnt;
   logic [6:0]    rx_sh;
   logic [7:0]    tx_sh;
   logic [7:0]    addr_hi;
   logic [AW-1:0] addr;
   logic          miso_q;
   logic          load_tx;
   logic          is_read;
   logic          wrote;
   wop_t          pend_op;
   logic [7:0]    mem [MEM_DEPTH];

   logic       lead_c, trail_c, sample_c, shift_c;
   logic       cs_fall_c, cs_rise_c;
   logic       do_sample_c, do_shift_c, byte_done_c, wr_en_c;
   logic [7:0] rx_full_c;

   // Pin synchronizers; CS resets low so a CS held low through reset never looks like a fall.
   always_ff @(posedge bus2ip_clk) begin
      if (rst) begin
         sck_sync  <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
      end else begin
         sck_sync  <= {sck_sync[1:0], SPI_SCK};
         cs_sync   <= {cs_sync[1:0], SPI_CS};
         mosi_sync <= {mosi_sync[0], SPI_MOSI};
      end
   end

   assign lead_c      = (sck_sync[2] == cpol) && (sck_sync[1] != cpol);
   assign trail_c     = (sck_sync[2] != cpol) && (sck_sync[1] == cpol);
   assign sample_c    = cpha ? trail_c : lead_c;
   assign shift_c     = cpha ? lead_c : trail_c;
   assign cs_fall_c   = cs_sync[2] & ~cs_sync[1];
   assign cs_rise_c   = ~cs_sync[2] & cs_sync[1];
   assign do_sample_c = (state != IDLE) && sample_c && !cs_rise_c;
   assign do_shift_c  = (state != IDLE) && shift_c && !cs_rise_c;
   assign rx_full_c   = {rx_sh, mosi_sync[1]};
   assign byte_done_c = do_sample_c && (bit_cnt == 3'd7);
   assign wr_en_c     = byte_done_c && (state == WRITE) && wel;

   always_ff @(posedge bus2ip_clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cs_rise_c) begin
         state_nxt = IDLE;
      end else if (cs_fall_c) begin
         state_nxt = CMD;
      end else if (byte_done_c) begin
         case (state)
            CMD: begin
               case (rx_full_c)
                  8'h03, 8'h02: state_nxt = ADDR_HI;
                  8'h05:        state_nxt = RDSR;
                  8'h01:        state_nxt = WRSR;
                  default:      state_nxt = IGNORE;
               endcase
            end
            ADDR_HI: state_nxt = ADDR_LO;
            ADDR_LO: state_nxt = is_read ? READ : WRITE;
            WRSR:    state_nxt = IGNORE;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge bus2ip_clk) begin
      if (rst) begin
         bit_cnt  <= '0;
         rx_sh    <= '0;
         tx_sh    <= 8'hFF;
         addr_hi  <= '0;
         addr     <= '0;
         miso_q   <= 1'b1;
         SPI_MISO <= 1'b1;
         load_tx  <= 1'b0;
         is_read  <= 1'b0;
         wrote    <= 1'b0;
         pend_op  <= WOP_NONE;
         wel      <= 1'b0;
         bp       <= 2'b00;
         rx_valid <= 1'b0;
         rx_byte  <= 8'h00;
      end else begin
         SPI_MISO <= miso_q;
         rx_valid <= 1'b0;
         load_tx  <= byte_done_c;
         if (cs_rise_c) begin
            miso_q  <= 1'b1;
            bit_cnt <= '0;
            // A pending WREN/WRDI only counts if the frame ended on the byte boundary.
            if (pend_op == WOP_SET && bit_cnt == 3'd0)      wel <= 1'b1;
            else if (pend_op == WOP_CLR && bit_cnt == 3'd0) wel <= 1'b0;
            else if (wrote)                                 wel <= 1'b0;
            pend_op <= WOP_NONE;
            wrote   <= 1'b0;
         end else if (cs_fall_c) begin
            miso_q  <= 1'b1;
            bit_cnt <= '0;
            tx_sh   <= 8'hFF;
            pend_op <= WOP_NONE;
            wrote   <= 1'b0;
         end else begin
            if (do_sample_c) begin
               bit_cnt <= bit_cnt + 3'd1;
               rx_sh   <= rx_full_c[6:0];
               if (state == IGNORE) pend_op <= WOP_NONE;
            end
            if (byte_done_c) begin
               rx_valid <= 1'b1;
               rx_byte  <= rx_full_c;
               case (state)
                  CMD: begin
                     is_read <= (rx_full_c == 8'h03);
                     if (rx_full_c == 8'h06)      pend_op <= WOP_SET;
                     else if (rx_full_c == 8'h04) pend_op <= WOP_CLR;
                  end
                  ADDR_HI: addr_hi <= rx_full_c;
                  ADDR_LO: addr    <= AW'({addr_hi, rx_full_c});
                  READ:    addr    <= addr + AW'(1);
                  WRITE: begin
                     if (wel) wrote <= 1'b1;
                     addr <= (addr & ~PAGE_MASK) | ((addr + AW'(1)) & PAGE_MASK);
                  end
                  WRSR: begin
                     if (wel) begin
                        bp    <= rx_full_c[3:2];
                        wrote <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            if (do_shift_c) miso_q <= tx_sh[~bit_cnt];
            // Next outgoing byte is fetched the cycle after the state/address update.
            if (load_tx) begin
               case (state)
                  READ:    tx_sh <= ~mem[addr];
                  RDSR:    tx_sh <= {4'b0000, bp, wel, 1'b0};
                  default: tx_sh <= 8'hFF;
               endcase
            end
         end
      end
   end

   // Array holds inverted data so a zero-initialised array reads back as erased 0xFF.
   always_ff @(posedge bus2ip_clk) begin
      if (wr_en_c) mem[addr] <= ~rx_full_c;
   end

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Self-checking bench for spi_eeprom_responder: directed scenarios plus random
// transactions checked against a byte-level EEPROM model.
module tb_spi_eeprom_responder;
   localparam int unsigned MEM_DEPTH = 256;
   localparam int unsigned PAGE_SIZE = 16;
   localparam int H = 6;

   logic       bus2ip_clk = 1'b0;
   logic       rst;
   logic       cpol, cpha;
   logic       SPI_SCK, SPI_CS, SPI_MOSI;
   logic       SPI_MISO;
   logic       wel;
   logic [1:0] bp;
   logic       rx_valid;
   logic [7:0] rx_byte;

   spi_eeprom_responder #(.MEM_DEPTH(MEM_DEPTH), .PAGE_SIZE(PAGE_SIZE)) dut (
      .bus2ip_clk(bus2ip_clk),
      .rst       (rst),
      .cpol      (cpol),
      .cpha      (cpha),
      .SPI_SCK   (SPI_SCK),
      .SPI_CS    (SPI_CS),
      .SPI_MOSI  (SPI_MOSI),
      .SPI_MISO  (SPI_MISO),
      .wel       (wel),
      .bp        (bp),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte)
   );

   always #5 bus2ip_clk = ~bus2ip_clk;

   int n_checks = 0;
   int n_errors = 0;
   int rx_cnt   = 0;

   logic [7:0] tx_buf  [16];
   logic [7:0] rx_buf  [16];
   logic [7:0] exp_buf [16];
   logic [7:0] mem_m   [MEM_DEPTH];
   logic       wel_m;
   logic [1:0] bp_m;

   always @(negedge bus2ip_clk) if (rx_valid) rx_cnt++;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge bus2ip_clk);
   endtask

   task automatic set_mode(input logic p, input logic h);
      cpol    = p;
      cpha    = h;
      SPI_SCK = p;
      wait_clk(2 * H);
   endtask

   // Byte-level EEPROM behaviour: fills exp_buf with the MISO bytes and updates model state.
   task automatic model_xfer(input int nbits);
      int nb;
      int a;
      int base;
      bit stored;
      nb = nbits / 8;
      a  = 0;
      for (int k = 0; k < 16; k++) exp_buf[k] = 8'hFF;
      if (nb == 0) return;
      if (nb >= 3) a = int'({tx_buf[1], tx_buf[2]}) % MEM_DEPTH;
      base = a - (a % PAGE_SIZE);
      case (tx_buf[0])
         8'h03: for (int k = 3; k < nb; k++) exp_buf[k] = mem_m[(a + k - 3) % MEM_DEPTH];
         8'h02: begin
            stored = 1'b0;
            for (int k = 3; k < nb; k++) begin
               if (wel_m) begin
                  mem_m[base + ((a % PAGE_SIZE) + k - 3) % PAGE_SIZE] = tx_buf[k];
                  stored = 1'b1;
               end
            end
            if (stored) wel_m = 1'b0;
         end
         8'h05: for (int k = 1; k < nb; k++) exp_buf[k] = {4'b0000, bp_m, wel_m, 1'b0};
         8'h01: begin
            if (nb >= 2 && wel_m) begin
               bp_m  = tx_buf[1][3:2];
               wel_m = 1'b0;
            end
         end
         8'h06: if (nbits == 8) wel_m = 1'b1;
         8'h04: if (nbits == 8) wel_m = 1'b0;
         default: ;
      endcase
   endtask

   task automatic spi_bits(input int nbits);
      int bi;
      int bj;
      for (int i = 0; i < nbits; i++) begin
         bi = i / 8;
         bj = 7 - (i % 8);
         if (!cpha) begin
            SPI_MOSI = tx_buf[bi][bj];
            wait_clk(H);
            rx_buf[bi][bj] = SPI_MISO;
            SPI_SCK = ~cpol;
            wait_clk(H);
            SPI_SCK = cpol;
         end else begin
            SPI_SCK  = ~cpol;
            SPI_MOSI = tx_buf[bi][bj];
            wait_clk(H);
            rx_buf[bi][bj] = SPI_MISO;
            SPI_SCK = cpol;
            wait_clk(H);
         end
      end
      wait_clk(H);
   endtask

   task automatic txn(input int nbits);
      int nb;
      int rx0;
      nb  = nbits / 8;
      rx0 = rx_cnt;
      for (int k = 0; k < 16; k++) rx_buf[k] = 8'h00;
      model_xfer(nbits);
      SPI_CS = 1'b0;
      wait_clk(H);
      spi_bits(nbits);
      SPI_CS = 1'b1;
      wait_clk(2 * H);
      for (int k = 0; k < nb; k++) check_eq($sformatf("miso[%0d] cmd%0h", k, tx_buf[0]), 32'(rx_buf[k]), 32'(exp_buf[k]));
      check_eq("rx_valid_count", 32'(rx_cnt - rx0), 32'(nb));
      if (nb > 0) check_eq("rx_byte", 32'(rx_byte), 32'(tx_buf[nb - 1]));
      check_eq("wel", 32'(wel), 32'(wel_m));
      check_eq("bp", 32'(bp), 32'(bp_m));
   endtask

   task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
      tx_buf[0] = b0;
      tx_buf[1] = b1;
      tx_buf[2] = b2;
      tx_buf[3] = b3;
      tx_buf[4] = b4;
   endtask

   task automatic scen_write_read(input string tag);
      load(8'h06, 8'h00, 8'h00, 8'h00, 8'h00);
      txn(8);
      load(8'h02, 8'h00, 8'h10, 8'hA5, 8'h5A);
      txn(40);
      check_eq({tag, "_wel_after_write"}, 32'(wel), 32'd0);
      load(8'h03, 8'h00, 8'h10, 8'hFF, 8'hFF);
      txn(40);
      check_eq({tag, "_rd0"}, 32'(rx_buf[3]), 32'hA5);
      check_eq({tag, "_rd1"}, 32'(rx_buf[4]), 32'h5A);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int op;
      int n;
      logic [15:0] a16;
      for (int k = 0; k < MEM_DEPTH; k++) mem_m[k] = 8'hFF;
      wel_m = 1'b0;
      bp_m  = 2'b00;
      rst = 1'b1; cpol = 1'b0; cpha = 1'b0;
      SPI_SCK = 1'b0; SPI_CS = 1'b1; SPI_MOSI = 1'b0;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(1);
      check_eq("reset_miso", 32'(SPI_MISO), 32'd1);
      check_eq("reset_wel", 32'(wel), 32'd0);
      check_eq("reset_bp", 32'(bp), 32'd0);
      check_eq("reset_rx_valid", 32'(rx_valid), 32'd0);
      check_eq("reset_rx_byte", 32'(rx_byte), 32'd0);
      wait_clk(2 * H);

      scen_write_read("mode0");

      load(8'h02, 8'h00, 8'h20, 8'h11, 8'h00);
      txn(32);
      load(8'h03, 8'h00, 8'h20, 8'h00, 8'h00);
      txn(32);
      check_eq("nowren_read", 32'(rx_buf[3]), 32'hFF);

      load(8'h06, 8'h00, 8'h00, 8'h00, 8'h00); txn(8);
      load(8'h05, 8'h00, 8'h00, 8'h00, 8'h00); txn(16);
      check_eq("rdsr_wren", 32'(rx_buf[1]), 32'h02);
      load(8'h04, 8'h00, 8'h00, 8'h00, 8'h00); txn(8);
      load(8'h05, 8'h00, 8'h00, 8'h00, 8'h00); txn(16);
      check_eq("rdsr_wrdi", 32'(rx_buf[1]), 32'h00);
      load(8'h06, 8'h00, 8'h00, 8'h00, 8'h00); txn(8);
      load(8'h01, 8'h0C, 8'h00, 8'h00, 8'h00); txn(16);
      load(8'h05, 8'h00, 8'h00, 8'h00, 8'h00); txn(16);
      check_eq("rdsr_wrsr", 32'(rx_buf[1]), 32'h0C);
      check_eq("bp_after_wrsr", 32'(bp), 32'd3);
      check_eq("wel_after_wrsr", 32'(wel), 32'd0);

      load(8'h06, 8'h00, 8'h00, 8'h00, 8'h00); txn(8);
      load(8'h02, 8'h00, 8'h1E, 8'h01, 8'h02);
      tx_buf[5] = 8'h03;
      tx_buf[6] = 8'h04;
      txn(56);
      load(8'h03, 8'h00, 8'h10, 8'h00, 8'h00); txn(40);
      check_eq("page_wrap_10", 32'(rx_buf[3]), 32'h03);
      check_eq("page_wrap_11", 32'(rx_buf[4]), 32'h04);
      load(8'h03, 8'h00, 8'h1E, 8'h00, 8'h00); txn(40);
      check_eq("page_wrap_1e", 32'(rx_buf[3]), 32'h01);
      check_eq("page_wrap_1f", 32'(rx_buf[4]), 32'h02);
      load(8'h03, 8'h00, 8'hFF, 8'h00, 8'h00);
      tx_buf[5] = 8'h00;
      txn(48);

      set_mode(1'b0, 1'b1); scen_write_read("mode1");
      set_mode(1'b1, 1'b0); scen_write_read("mode2");
      set_mode(1'b1, 1'b1); scen_write_read("mode3");

      // Reset in the middle of a READ with CS held low.
      set_mode(1'b0, 1'b0);
      load(8'h03, 8'h00, 8'h10, 8'hFF, 8'h00);
      SPI_CS = 1'b0;
      wait_clk(H);
      spi_bits(28);
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      wel_m = 1'b0;
      bp_m  = 2'b00;
      wait_clk(1);
      check_eq("midrst_bp", 32'(bp), 32'd0);
      check_eq("midrst_rx_byte", 32'(rx_byte), 32'd0);
      n = rx_cnt;
      for (int p = 0; p < 4; p++) begin
         SPI_SCK = ~cpol;
         wait_clk(H);
         check_eq("midrst_miso_hi", 32'(SPI_MISO), 32'd1);
         SPI_SCK = cpol;
         wait_clk(H);
         check_eq("midrst_miso_lo", 32'(SPI_MISO), 32'd1);
      end
      check_eq("midrst_no_rx_valid", 32'(rx_cnt - n), 32'd0);
      SPI_CS = 1'b1;
      wait_clk(2 * H);
      load(8'h03, 8'h00, 8'h10, 8'h00, 8'h00);
      txn(32);
      check_eq("after_rst_read", 32'(rx_buf[3]), 32'hA5);
      load(8'h06, 8'h00, 8'h00, 8'h00, 8'h00);
      txn(7);
      check_eq("wren_7bits", 32'(wel), 32'd0);

      for (int it = 0; it < 30; it++) begin
         set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         op  = int'($urandom_range(0, 6));
         a16 = 16'($urandom) & 16'h0F3F;
         for (int k = 0; k < 16; k++) tx_buf[k] = 8'($urandom);
         tx_buf[1] = a16[15:8];
         tx_buf[2] = a16[7:0];
         n = int'($urandom_range(1, 6));
         case (op)
            0: begin tx_buf[0] = 8'h06; txn(($urandom_range(0, 3) == 0) ? 16 : 8); end
            1: begin tx_buf[0] = 8'h04; txn(8); end
            2: begin tx_buf[0] = 8'h02; txn(8 * (3 + n)); end
            3: begin tx_buf[0] = 8'h03; txn(8 * (3 + n)); end
            4: begin tx_buf[0] = 8'h05; txn(8 * (1 + (n % 3) + 1)); end
            5: begin tx_buf[0] = 8'h01; txn(16); end
            default: begin tx_buf[0] = 8'hA0 | 8'(n); txn(8 * (1 + (n % 2) + 1)); end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
